// File: rtl/clkout_ctrl_pkg.sv
// Shared state encoding and default widths for the clock-output sequencer.
package clkout_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/clkout_divcnt.sv
// Half-period counter: holds the latched divisor and flags the last cycle of each phase.
module clkout_divcnt
    import clkout_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    input  logic             clr,
    input  logic             en,
    output logic             tc
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    // Equality compare only: cnt never passes div_q, so no wrap case exists.
    assign tc = (cnt == div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_q <= div_in;
            cnt   <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clkout_ctrl.sv
// Glitch-free divided clock output with start/stop handshake.
// Optional burst mode (fixed number of rising edges) under CLKOUT_BURST_EN.
module clkout_ctrl
    import clkout_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
`ifdef CLKOUT_BURST_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_in,
    input  logic             start,
    input  logic             stop,
`ifdef CLKOUT_BURST_EN
    input  logic [CNT_W-1:0] burst_len,
`endif
    output logic             busy,
    output logic             clk_out,
    output logic             edge_stb,
    output logic             done
);

    state_t state;
    state_t nxt;
    logic   tc;
    logic   load;
    logic   clr;
    logic   en;
    logic   burst_hit;
    logic   stop_eff;
    logic   clk_out_d;

    assign load = (state == ST_IDLE) && start;
    assign clr  = (state == ST_IDLE) && !start;
    assign en   = (state != ST_IDLE);

    clkout_divcnt #(.DIV_W(DIV_W)) u_divcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .div_in (div_in),
        .clr    (clr),
        .en     (en),
        .tc     (tc)
    );

`ifdef CLKOUT_BURST_EN
    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] rise_cnt;

    // The start edge is itself the first rise, so the count begins at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q  <= '0;
            rise_cnt <= '0;
        end else if (load) begin
            burst_q  <= burst_len;
            rise_cnt <= CNT_W'(1);
        end else if ((state == ST_RUN) && clk_out_d && !clk_out) begin
            rise_cnt <= rise_cnt + 1'b1;
        end
    end

    // Behaves as an internal stop raised during the final high phase.
    assign burst_hit = (burst_q != '0) && (rise_cnt == burst_q) && clk_out;
`else
    assign burst_hit = 1'b0;
`endif

    assign stop_eff = stop | burst_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            clk_out  <= 1'b0;
            busy     <= 1'b0;
            edge_stb <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= nxt;
            clk_out  <= clk_out_d;
            busy     <= (nxt != ST_IDLE);
            edge_stb <= clk_out_d & ~clk_out;
            done     <= (state != ST_IDLE) && (nxt == ST_IDLE);
        end
    end

    // A stop seen while high either ends now (phase already complete) or drains.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (start) nxt = ST_RUN;
            ST_RUN:   if (stop_eff) nxt = (!clk_out || tc) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (tc) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        clk_out_d = 1'b0;
        case (state)
            ST_IDLE:  clk_out_d = start;
            ST_RUN:   clk_out_d = (stop_eff && !clk_out) ? 1'b0 : (clk_out ^ tc);
            ST_DRAIN: clk_out_d = clk_out & ~tc;
            default:  clk_out_d = 1'b0;
        endcase
    end

endmodule
